// File: rtl/alu_op_issuer.sv
// alu_op_issuer: front-end sequencer for the registered ALU.
// Takes one decoded op at a time over a valid/ready request channel, drives the
// ALU operands and a single-cycle enable, captures the ALU's registered result
// and flags, and presents them on a valid/ready response channel for writeback.
// Optional build macro STICKY_OVF_EN adds a sticky overflow flag (sticky_ovf)
// with its clear input (sticky_clr).
module alu_op_issuer #(
   parameter int WORD_SIZE = 16,
   parameter int RD_W      = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [3:0]           req_op,
   input  logic [WORD_SIZE-1:0] req_a,
   input  logic [WORD_SIZE-1:0] req_b,
   input  logic [RD_W-1:0]      req_rd,
   output logic [WORD_SIZE-1:0] alu_in1,
   output logic [WORD_SIZE-1:0] alu_in2,
   output logic [2:0]           alu_ctrl,
   output logic                 alu_en,
   input  logic [WORD_SIZE-1:0] alu_result,
   input  logic                 alu_zero,
   input  logic                 alu_overflow,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [WORD_SIZE-1:0] rsp_data,
   output logic [RD_W-1:0]      rsp_rd,
   output logic                 rsp_we,
   output logic                 rsp_zero,
   output logic                 rsp_ovf,
   output logic                 rsp_err
`ifdef STICKY_OVF_EN
   ,
   output logic                 sticky_ovf,
   input  logic                 sticky_clr
`endif
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      RESP    = 2'd3
   } state_t;

   state_t state, state_nxt;

   // Latched request
   logic [WORD_SIZE-1:0] a_q;
   logic [WORD_SIZE-1:0] b_q;
   logic [RD_W-1:0]      rd_q;
   logic [2:0]           ctrl_q;
   logic                 we_q;
   logic                 ovf_mask_q;

   logic accept;
   logic req_legal;
   logic cap_ovf;

   // Ops 0x0-0x9 are defined; 0xA-0xF are illegal.
   function automatic logic op_is_legal(input logic [3:0] op);
      return (op <= 4'h9);
   endfunction

   // Decoded op -> ALUControl. CMP reuses SUB, TST reuses AND.
   function automatic logic [2:0] op_to_ctrl(input logic [3:0] op);
      logic [2:0] ctrl;
      case (op)
         4'h0, 4'h1, 4'h2, 4'h3,
         4'h4, 4'h5, 4'h6, 4'h7: ctrl = op[2:0];
         4'h8:                   ctrl = 3'b110;
         4'h9:                   ctrl = 3'b000;
         default:                ctrl = 3'b111;
      endcase
      return ctrl;
   endfunction

   // Only the plain ALU ops write a destination; CMP/TST are flag-only.
   function automatic logic op_writes(input logic [3:0] op);
      return (op <= 4'h7);
   endfunction

   // Overflow is meaningful only for ADD, MUL, SUB and CMP.
   function automatic logic op_ovf_valid(input logic [3:0] op);
      logic v;
      case (op)
         4'h4, 4'h5, 4'h6, 4'h8: v = 1'b1;
         default:                v = 1'b0;
      endcase
      return v;
   endfunction

   assign accept    = (state == IDLE) && req_valid;
   assign req_legal = op_is_legal(req_op);
   assign cap_ovf   = alu_overflow & ovf_mask_q;

   // ALU operands and control always reflect the latched request
   assign alu_in1  = a_q;
   assign alu_in2  = b_q;
   assign alu_ctrl = ctrl_q;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; illegal ops skip the ALU and answer immediately
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (req_valid) begin
               state_nxt = req_legal ? ISSUE : RESP;
            end
         end
         ISSUE:   state_nxt = CAPTURE;
         CAPTURE: state_nxt = RESP;
         RESP: begin
            if (rsp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State-decoded handshake and enable outputs
   always_comb begin
      req_ready = 1'b0;
      alu_en    = 1'b0;
      rsp_valid = 1'b0;
      case (state)
         IDLE:    req_ready = 1'b1;
         ISSUE:   alu_en    = 1'b1;
         RESP:    rsp_valid = 1'b1;
         default: ;
      endcase
   end

   // Request latch: captured on acceptance, held until the next accepted request
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q        <= '0;
         b_q        <= '0;
         rd_q       <= '0;
         ctrl_q     <= 3'b111;
         we_q       <= 1'b0;
         ovf_mask_q <= 1'b0;
      end else if (accept) begin
         a_q        <= req_a;
         b_q        <= req_b;
         rd_q       <= req_rd;
         ctrl_q     <= op_to_ctrl(req_op);
         we_q       <= op_writes(req_op);
         ovf_mask_q <= op_ovf_valid(req_op);
      end
   end

   // Response registers: loaded with an error reply on an illegal accept, or with
   // the ALU outputs in CAPTURE; otherwise held so they stay stable through RESP
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_data <= '0;
         rsp_rd   <= '0;
         rsp_we   <= 1'b0;
         rsp_zero <= 1'b0;
         rsp_ovf  <= 1'b0;
         rsp_err  <= 1'b0;
      end else if (accept && !req_legal) begin
         rsp_data <= '0;
         rsp_rd   <= req_rd;
         rsp_we   <= 1'b0;
         rsp_zero <= 1'b0;
         rsp_ovf  <= 1'b0;
         rsp_err  <= 1'b1;
      end else if (state == CAPTURE) begin
         rsp_data <= alu_result;
         rsp_rd   <= rd_q;
         rsp_we   <= we_q;
         rsp_zero <= alu_zero;
         rsp_ovf  <= cap_ovf;
         rsp_err  <= 1'b0;
      end
   end

`ifdef STICKY_OVF_EN
   // Sticky overflow: set by a captured (masked) overflow, cleared on request; set wins
   always_ff @(posedge clk) begin
      if (rst) begin
         sticky_ovf <= 1'b0;
      end else if ((state == CAPTURE) && cap_ovf) begin
         sticky_ovf <= 1'b1;
      end else if (sticky_clr) begin
         sticky_ovf <= 1'b0;
      end
   end
`endif

endmodule
